// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and defaults for the round-robin adder-sharing arbiter.
package adder_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_NREQ  = 4;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  winner,
  output logic [NREQ-1:0] onehot
);

  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest set bit after ptr wins last.
  always_comb begin
    valid  = |req;
    winner = '0;
    onehot = '0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + IDW'(i);
      if (req[idx]) winner = idx;
    end
    if (valid) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Arbiter FSM sharing one registered adder among NREQ requesters; returns tagged sums.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  localparam int IDW  = idw_of(NREQ)
) (
  input  logic                    gclk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [WIDTH:0]          sum
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic             pick_valid;
  logic [IDW-1:0]   pick_winner;
  logic [NREQ-1:0]  pick_onehot;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner),
    .onehot (pick_onehot)
  );

  // gnt and done are pulses: they default low and are only set on the transition cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          a_d     = op_a[int'(pick_winner)*WIDTH +: WIDTH];
          b_d     = op_b[int'(pick_winner)*WIDTH +: WIDTH];
          id_d    = pick_winner;
          gnt_d   = pick_onehot;
          ptr_d   = pick_winner + IDW'(1);
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d     = {1'b0, a_q} + {1'b0, b_q};
        done_id_d = id_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign busy    = (state_q == ADD);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: requester model, monitor, directed vectors.
module tb_adder_share_arbiter;

  localparam int WIDTH = 2;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [WIDTH:0] sum;
  } done_exp_t;

  logic                  gclk;
  logic                  resetn;
  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [WIDTH:0]        sum;

  logic [NREQ-1:0] exp_gnt_q[$];
  done_exp_t       exp_done_q[$];
  int              pend[NREQ];
  int              n_checks;
  int              n_errors;
  int              cyc;
  int              last_done_cyc;
  bit              spacing_armed;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .gclk    (gclk),
    .resetn  (resetn),
    .en      (en),
    .req     (req),
    .op_a    (op_a),
    .op_b    (op_b),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setOps(input int i, input int a, input int b);
    op_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    op_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic expectResult(input int i, input int s);
    done_exp_t e;
    e.id  = IDW'(i);
    e.sum = (WIDTH + 1)'(s);
    exp_gnt_q.push_back(NREQ'(1) << i);
    exp_done_q.push_back(e);
  endtask

  task automatic applyStimulus(input int i, input int count);
    pend[i] = count;
  endtask

  task automatic stepCycle();
    @(posedge gclk);
    #2;
  endtask

  task automatic waitIdle(input int bound);
    int  k;
    bit  idle;
    idle = 1'b0;
    for (k = 0; k < bound; k++) begin
      stepCycle();
      if (exp_gnt_q.size() == 0 && exp_done_q.size() == 0 && !busy &&
          pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && pend[3] == 0) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL wait_idle_timeout: got %0d pending results, expected 0", exp_done_q.size());
      exp_gnt_q.delete();
      exp_done_q.delete();
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
    end
  endtask

  // Requester model: req follows pending work, drops on the grant cycle, re-raises a cycle later.
  initial begin
    req = '0;
    forever begin
      @(negedge gclk);
      for (int i = 0; i < NREQ; i++) begin
        if (!resetn) begin
          req[i] = 1'b0;
        end else if (gnt[i]) begin
          req[i] = 1'b0;
          if (pend[i] > 0) pend[i]--;
        end else begin
          req[i] = (pend[i] > 0);
        end
      end
    end
  end

  // Monitor: pops expected grants and results whenever the DUT presents them.
  initial begin
    done_exp_t e;
    last_done_cyc = 0;
    forever begin
      @(negedge gclk);
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) begin
          checkOutput("unexpected_gnt", int'(gnt), 0);
        end else begin
          checkOutput("gnt", int'(gnt), int'(exp_gnt_q.pop_front()));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          checkOutput("unexpected_done", int'(done_id), -1);
        end else begin
          e = exp_done_q.pop_front();
          checkOutput("done_id", int'(done_id), int'(e.id));
          checkOutput("sum", int'(sum), int'(e.sum));
        end
        if (spacing_armed && last_done_cyc != 0)
          checkOutput("done_spacing", cyc - last_done_cyc, 2);
        last_done_cyc = cyc;
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    cyc           = 0;
    spacing_armed = 1'b0;
    en            = 1'b1;
    resetn        = 1'b0;
    op_a          = '0;
    op_b          = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;

    repeat (3) stepCycle();
    checkOutput("reset_gnt", int'(gnt), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done_id", int'(done_id), 0);
    checkOutput("reset_sum", int'(sum), 0);
    resetn = 1'b1;
    stepCycle();

    // Single request on requester 2 with 3+3, latency checked cycle by cycle.
    setOps(2, 3, 3);
    expectResult(2, 6);
    applyStimulus(2, 1);
    stepCycle();
    checkOutput("t1_gnt", int'(gnt), 4);
    checkOutput("t1_busy", int'(busy), 1);
    stepCycle();
    checkOutput("t1_done", int'(done), 1);
    checkOutput("t1_done_id", int'(done_id), 2);
    checkOutput("t1_sum", int'(sum), 6);
    checkOutput("t1_busy_after", int'(busy), 0);
    waitIdle(20);

    // Exhaustive operand pairs on requester 3 (ptr is 3 here, ends at 0).
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        setOps(3, a, b);
        expectResult(3, a + b);
        applyStimulus(3, 1);
        waitIdle(20);
      end
    end

    // All four requesting: order 0,1,2,3,0 with a done every 2 cycles.
    for (int i = 0; i < NREQ; i++) setOps(i, i, (i + 1) % 4);
    expectResult(0, 1);
    expectResult(1, 3);
    expectResult(2, 5);
    expectResult(3, 3);
    expectResult(0, 1);
    last_done_cyc = 0;
    spacing_armed = 1'b1;
    applyStimulus(0, 2);
    applyStimulus(1, 1);
    applyStimulus(2, 1);
    applyStimulus(3, 1);
    waitIdle(60);
    spacing_armed = 1'b0;

    // Wrap-around: grant 1 moves ptr to 2, then 0 wins over 1.
    expectResult(1, 3);
    applyStimulus(1, 1);
    waitIdle(20);
    expectResult(0, 1);
    expectResult(1, 3);
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    waitIdle(40);

    // Enable low blocks grants; dropping it during ADD still lets done pulse.
    en = 1'b0;
    applyStimulus(0, 1);
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput("en_low_gnt", int'(gnt), 0);
    end
    expectResult(0, 1);
    en = 1'b1;
    stepCycle();
    checkOutput("en_rise_gnt", int'(gnt), 1);
    en = 1'b0;
    waitIdle(20);
    en = 1'b1;

    // Reset in the grant cycle discards the add; next grant goes to requester 1.
    applyStimulus(0, 1);
    stepCycle();
    checkOutput("rst_pre_gnt", int'(gnt), 1);
    resetn = 1'b0;
    pend[0] = 0;
    #1;
    checkOutput("rst_gnt", int'(gnt), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done_id", int'(done_id), 0);
    checkOutput("rst_sum", int'(sum), 0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("rst_done", int'(done), 0);
    end
    resetn = 1'b1;
    stepCycle();
    expectResult(1, 3);
    applyStimulus(1, 1);
    stepCycle();
    checkOutput("post_rst_gnt", int'(gnt), 2);
    waitIdle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
